// File: rtl/demux_pkg.sv
// Shared types and the round-robin lane search used by the lane deserializer.
package demux_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic  valid;
    lane_t lane;
  } pick_t;

  // Walk from the farthest offset down to rr itself so the nearest full lane wins.
  function automatic pick_t rr_next_lane(input lane_t rr, input logic [LANES-1:0] full);
    pick_t p;
    lane_t idx;
    p = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      idx = rr + lane_t'(i);
      if (full[idx]) begin
        p.valid = 1'b1;
        p.lane  = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/demux_lane_acc.sv
// One lane: MSB-first shift register, bit counter, holding register and overflow detect.
module demux_lane_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             bit_in,
  input  logic             pop,
  output logic [WIDTH-1:0] word,
  output logic             full,
  output logic             ovf_pulse
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Only WIDTH-1 bits need storing; the WIDTH-th arrives with the completing strobe.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] assembled;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    full_d    = full_q & ~pop;
    ovf_pulse = 1'b0;
    assembled = {shift_q, bit_in};
    if (cap_en) begin
      shift_d = assembled[WIDTH-2:0];
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d = '0;
        if (full_q && !pop) begin
          ovf_pulse = 1'b1;
        end else begin
          hold_d = assembled;
          full_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the hold register is reset too, so a word discarded by reset can never reappear.
  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
    end
  end

  assign word = hold_q;
  assign full = full_q;

endmodule

// File: rtl/demux_lane_deser.sv
// Four-lane deserializer behind a 1:4 demux with a round-robin valid/ready output.
module demux_lane_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [1:0]       S,
  input  logic             Y0,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             Y3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_lane,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       overflow,
  output logic             sel_err,
  input  logic             clear_flags
);

  logic [LANES-1:0] y_vec;
  logic             bit_sel;
  logic             sel_bad;
  logic [LANES-1:0] cap_en, pop, full, ovf_pulse;
  logic [WIDTH-1:0] word [LANES];
  logic             xfer;
  pick_t            pick;

  lane_t            rr_q, rr_d;
  logic [LANES-1:0] ovf_q, ovf_d;
  logic             sel_err_q, sel_err_d;

  assign y_vec   = {Y3, Y2, Y1, Y0};
  assign bit_sel = y_vec[S];
  assign sel_bad = bit_valid && |(y_vec & ~(4'b0001 << S));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_acc #(.WIDTH(WIDTH)) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_en    (cap_en[g]),
      .bit_in    (bit_sel),
      .pop       (pop[g]),
      .word      (word[g]),
      .full      (full[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // Output side depends only on registered full/hold/rr, never on out_ready.
  always_comb begin
    pick      = rr_next_lane(rr_q, full);
    out_valid = pick.valid;
    out_lane  = pick.lane;
    out_data  = pick.valid ? word[pick.lane] : '0;
    xfer      = pick.valid & out_ready;
    for (int i = 0; i < LANES; i++) begin
      cap_en[i] = bit_valid && (S == lane_t'(i));
      pop[i]    = xfer && (pick.lane == lane_t'(i));
    end
    rr_d      = xfer ? pick.lane + 2'd1 : rr_q;
    // A set in the same cycle as clear_flags wins.
    ovf_d     = (clear_flags ? '0 : ovf_q) | ovf_pulse;
    sel_err_d = (clear_flags ? 1'b0 : sel_err_q) | sel_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      ovf_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      ovf_q     <= ovf_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign overflow = ovf_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_demux_lane_deser.sv
// Self-checking bench for demux_lane_deser: vector table, scoreboarded output, corner sequences.
module tb_demux_lane_deser;
  import demux_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_valid = 1'b0;
  logic [1:0]       S = '0;
  logic             Y0 = 1'b0, Y1 = 1'b0, Y2 = 1'b0, Y3 = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_lane;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       overflow;
  logic             sel_err;
  logic             clear_flags = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    lane_t            lane;
    logic [WIDTH-1:0] data;
  } exp_t;

  typedef struct packed {
    lane_t            in_lane;
    logic [WIDTH-1:0] in_word;
    lane_t            exp_lane;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  demux_lane_deser #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .S           (S),
    .Y0          (Y0),
    .Y1          (Y1),
    .Y2          (Y2),
    .Y3          (Y3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lane    (out_lane),
    .out_data    (out_data),
    .overflow    (overflow),
    .sel_err     (sel_err),
    .clear_flags (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted word is compared against the next expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got lane %0d data %0h expected no transfer", out_lane, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", {22'd0, out_lane, out_data}, {22'd0, e.lane, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    {Y3, Y2, Y1, Y0} = 4'b0000;
  endtask

  task automatic send_bit(input lane_t s, input logic b);
    logic [3:0] y;
    y = 4'({3'b000, b}) << s;
    bit_valid = 1'b1;
    S = s;
    {Y3, Y2, Y1, Y0} = y;
    tick();
  endtask

  task automatic send_word(input lane_t s, input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(s, w[i]);
    idle();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{in_lane: 2'd0, in_word: 8'hA6, exp_lane: 2'd0, exp_data: 8'hA6};
    vecs[1] = '{in_lane: 2'd1, in_word: 8'h5A, exp_lane: 2'd1, exp_data: 8'h5A};
    vecs[2] = '{in_lane: 2'd3, in_word: 8'h80, exp_lane: 2'd3, exp_data: 8'h80};
    vecs[3] = '{in_lane: 2'd2, in_word: 8'h01, exp_lane: 2'd2, exp_data: 8'h01};
    vecs[4] = '{in_lane: 2'd0, in_word: 8'hFF, exp_lane: 2'd0, exp_data: 8'hFF};
    vecs[5] = '{in_lane: 2'd2, in_word: 8'h00, exp_lane: 2'd2, exp_data: 8'h00};

    // Reset state
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_lane", 32'(out_lane), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_selerr", 32'(sel_err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-lane words with a ready sink; first row is the A6 lane-0 fill
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      sb.push_back('{lane: vecs[v].exp_lane, data: vecs[v].exp_data});
      send_word(vecs[v].in_lane, vecs[v].in_word);
      check("vec_valid", 32'(out_valid), 1);
      check("vec_lane", 32'(out_lane), 32'(vecs[v].exp_lane));
      check("vec_data", 32'(out_data), 32'(vecs[v].exp_data));
      tick();
      check("vec_drained", 32'(out_valid), 0);
    end

    // Interleave lanes 1 and 2 with all-ones while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_bit((i % 2 == 0) ? 2'd1 : 2'd2, 1'b1);
    idle();
    check("il_valid", 32'(out_valid), 1);
    check("il_lane", 32'(out_lane), 1);
    check("il_data", 32'(out_data), 32'hFF);
    sb.push_back('{lane: 2'd1, data: 8'hFF});
    sb.push_back('{lane: 2'd2, data: 8'hFF});
    out_ready = 1'b1;
    tick();
    check("il_second_lane", 32'(out_lane), 2);
    tick();
    check("il_drained", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Round-robin fairness from rr=0
    reset_dut();
    send_word(2'd3, 8'h33);
    send_word(2'd1, 8'h11);
    send_word(2'd0, 8'hC0);
    check("rr_first", 32'(out_lane), 0);
    check("rr_first_data", 32'(out_data), 32'hC0);
    sb.push_back('{lane: 2'd0, data: 8'hC0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rr_after0", 32'(out_lane), 1);
    send_word(2'd0, 8'h0F);
    check("rr_hold_lane", 32'(out_lane), 1);
    sb.push_back('{lane: 2'd1, data: 8'h11});
    sb.push_back('{lane: 2'd3, data: 8'h33});
    sb.push_back('{lane: 2'd0, data: 8'h0F});
    out_ready = 1'b1;
    tick();
    check("rr_after1", 32'(out_lane), 3);
    tick();
    check("rr_after3", 32'(out_lane), 0);
    tick();
    check("rr_drained", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Overflow on lane 3 keeps the old word
    send_word(2'd3, 8'h5C);
    check("ovf_pre", 32'(overflow), 0);
    send_word(2'd3, 8'hA3);
    check("ovf_set", 32'(overflow), 32'b1000);
    check("ovf_keep", 32'(out_data), 32'h5C);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    sb.push_back('{lane: 2'd3, data: 8'h5C});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ovf_drained", 32'(out_valid), 0);

    // Completion and pop on the same lane in the same cycle
    send_word(2'd2, 8'h11);
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(2'd2, 1'(8'h22 >> i));
    sb.push_back('{lane: 2'd2, data: 8'h11});
    sb.push_back('{lane: 2'd2, data: 8'h22});
    out_ready = 1'b1;
    send_bit(2'd2, 1'b0);
    idle();
    check("same_valid", 32'(out_valid), 1);
    check("same_data", 32'(out_data), 32'h22);
    check("same_no_ovf", 32'(overflow), 0);
    tick();
    check("same_drained", 32'(out_valid), 0);

    // Select error: Y0 high while lane 1 selected; lane 1 still captures 0
    bit_valid = 1'b1;
    S = 2'd1;
    {Y3, Y2, Y1, Y0} = 4'b0001;
    tick();
    idle();
    check("sel_err_set", 32'(sel_err), 1);
    for (int i = WIDTH - 2; i >= 0; i--) send_bit(2'd1, 1'(8'h35 >> i));
    sb.push_back('{lane: 2'd1, data: 8'h35});
    idle();
    check("sel_word", 32'(out_data), 32'h35);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("sel_err_clear", 32'(sel_err), 0);
    // Set in the same cycle as clear wins
    clear_flags = 1'b1;
    bit_valid = 1'b1;
    S = 2'd0;
    {Y3, Y2, Y1, Y0} = 4'b1000;
    tick();
    idle();
    clear_flags = 1'b0;
    check("sel_set_beats_clear", 32'(sel_err), 1);

    // Reset mid-word discards the partial lane-2 word
    for (int i = 0; i < 5; i++) send_bit(2'd2, 1'b1);
    idle();
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_selerr", 32'(sel_err), 0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    // Noise with bit_valid low must be ignored
    for (int i = 0; i < 4; i++) begin
      S = 2'($urandom_range(0, 3));
      {Y3, Y2, Y1, Y0} = 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    check("noise_ignored", 32'(out_valid), 0);
    sb.push_back('{lane: 2'd2, data: 8'h3C});
    send_word(2'd2, 8'h3C);
    check("post_rst_data", 32'(out_data), 32'h3C);
    tick();
    check("post_rst_drained", 32'(out_valid), 0);
    out_ready = 1'b0;
    tick();

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_lane_deser.md
# demux_lane_deser

Four-lane bit deserializer that sits directly downstream of the 1:4 demux. On each strobe it samples the demux outputs and shifts the routed bit into the shift register of the lane selected by `S`. When a lane has collected WIDTH bits, the word moves to that lane's holding register. Full holding registers are presented one at a time, round-robin, on a single valid/ready output port.

## Interface
- `WIDTH`, default 8: bits per assembled word (2..32).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `bit_valid` input 1: strobe; the routed bit is sampled on this edge.
- `S` input 2: lane select; the same value that drives the demux select.
- `Y0`, `Y1`, `Y2`, `Y3` input 1 each: demux outputs.
- `out_valid` output 1: at least one lane holds a complete word.
- `out_ready` input 1: downstream accepts the word.
- `out_lane` output 2: lane index of the presented word.
- `out_data` output WIDTH: presented word.
- `overflow` output 4: sticky per-lane flag; a completed word was dropped.
- `sel_err` output 1: sticky flag; a non-selected `Y` line was 1 while `bit_valid` was high.
- `clear_flags` input 1: synchronous clear of `overflow` and `sel_err`.

## Operation
- Bit capture: when `bit_valid`=1, bit b = Y[S].
  - b shifts into lane S, MSB-first: the first bit of a word ends up in `out_data[WIDTH-1]`.
  - The bit counter of lane S increments.
  - Lanes other than S are untouched.
- Select check: when `bit_valid`=1 and Y[k]=1 for any k≠S, set `sel_err`. The bit from Y[S] is still captured.
- Word completion: when lane L's counter reaches WIDTH-1 and a bit arrives:
  - the assembled word goes to hold[L];
  - full[L] is set;
  - the counter wraps to 0.
- Overflow: completion on lane L with full[L]=1 and no same-cycle pop of L:
  - the new word is dropped and hold[L] keeps the old word;
  - `overflow[L]` is set;
  - the counter still wraps to 0.
- Simultaneous completion and pop on the same lane:
  - the popped word leaves;
  - the new word loads and full[L] stays 1;
  - no overflow.
- Arbitration: round-robin pointer `rr` (2 bits).
  - The presented lane is the first lane with full=1, searching from `rr` upward with mod-4 wrap.
  - `out_valid` = OR of all full flags.
  - `out_lane` and `out_data` reflect the chosen lane. `out_data` is 0 when `out_valid`=0.
- Handshake: a transfer happens when `out_valid` and `out_ready` are both 1.
  - Clear full[`out_lane`].
  - Set `rr` = `out_lane`+1 (mod 4).
  - Without a transfer, `rr` holds and the presented word is stable.
- `out_valid` never drops without a transfer, except on reset.
- Flags: `clear_flags`=1 clears `overflow` and `sel_err`. Any set condition in the same cycle wins over the clear.

## Timing
- Reset values (async, `rst_n`=0):
  - all shift registers, counters, hold registers, full flags and `rr` = 0;
  - `out_valid`=0, `out_lane`=0, `out_data`=0, `overflow`=0, `sel_err`=0.
- Reset mid-word discards partial words and held words. No output is produced for them.
- Latency: the edge that samples the WIDTH-th bit sets full. `out_valid` is high in the cycle immediately after that edge (1-cycle latency).
- `out_valid`, `out_lane` and `out_data` are combinational from registered state. There is no combinational path from `out_ready` to `out_valid`.
- Throughput: one word per cycle on the output. Input rate is one bit per cycle, so output bandwidth always exceeds input bandwidth, provided `out_ready` is not held low.
- A 1-bit input with `bit_valid`=0 is ignored; `Y` and `S` are don't-care.

## Structure
- Shared package `demux_pkg`:
  - `LANES`=4;
  - `typedef logic [1:0] lane_t`;
  - the round-robin next-lane function (search from `rr`, wrap mod 4).
- Sub-module `demux_lane_acc`, instantiated 4 times. It contains:
  - the shift register and counter;
  - the hold register and full flag;
  - overflow detection.
  - Ports: capture enable, bit, pop, word, full, overflow pulse.
- The top level contains the Y[S] mux, the select check, the arbiter and `rr`, and the sticky flags.

## Test plan
- Lane 0 fill: WIDTH=8, `S`=0, bits 1,0,1,0,0,1,1,0 on 8 consecutive cycles, `out_ready`=1 → `out_valid` the next cycle, `out_lane`=0, `out_data`=8'hA6, then `out_valid`=0.
- Interleave: alternate `S`=1 and `S`=2 with all-ones bits for 16 cycles, `out_ready`=0 → two words held, lane 1 presented first with 8'hFF. Raise `out_ready` → lane 1 then lane 2 on consecutive cycles.
- Round-robin fairness: lanes 0, 1 and 3 all full, `rr`=0, `out_ready`=1 → order 0, 1, 3. Refill lane 0 → it is served after 3.
- Overflow: lane 3 full, `out_ready`=0, another 8 bits on `S`=3 → `overflow`=4'b1000 and the held word is unchanged. Then `clear_flags` → `overflow`=0.
- Select error: `bit_valid`=1, `S`=1, `Y0`=1, `Y1`=0 → `sel_err`=1 and lane 1 captures a 0.
- Reset mid-word: 5 bits into lane 2, pulse `rst_n` low, then 8 bits 8'h3C → a single word 8'h3C is output; no remnant of the partial word.
